// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the single-clock FIFO: issues RAM reads against the
// writer pointer and presents words first-word-fall-through via a 2-entry buffer.
module fifo_rd_ctrl #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW:0]   wr_ptr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          dout_ready,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_raddr,
    output logic [AW:0]   rd_ptr,
    output logic          empty,
    output logic [AW:0]   level,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          ovf_err
);

    logic          inflight_p1;
    logic [1:0]    buf_cnt;
    logic [DW-1:0] tail;
    logic          pop;
    logic [2:0]    occ;
    logic          overrun;
    logic [1:0]    cnt_nxt;
    logic [DW-1:0] head_nxt;
    logic [DW-1:0] tail_nxt;

    // Stage p0: issue decision against the live writer pointer
    assign empty     = (rd_ptr == wr_ptr);
    assign level     = wr_ptr - rd_ptr;
    assign mem_raddr = rd_ptr[AW-1:0];
    assign pop       = dout_valid & dout_ready;
    assign occ       = {1'b0, buf_cnt} + {2'b00, inflight_p1};
    assign mem_rd_en = rstn & ~empty & (occ < (3'd2 + {2'b00, pop}));
    assign overrun   = level[AW] & (|level[AW-1:0]);

    // Stage p1: capture returning RAM data behind any surviving entry
    always_comb begin
        head_nxt = dout;
        tail_nxt = tail;
        cnt_nxt  = buf_cnt;
        if (pop) begin
            cnt_nxt = buf_cnt - 2'd1;
            if (buf_cnt == 2'd2) begin
                head_nxt = tail;
            end
        end
        if (inflight_p1) begin
            if (cnt_nxt == 2'd0) begin
                head_nxt = mem_rdata;
            end else begin
                tail_nxt = mem_rdata;
            end
            cnt_nxt = cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr      <= '0;
            inflight_p1 <= 1'b0;
            buf_cnt     <= 2'd0;
            dout        <= '0;
            tail        <= '0;
            dout_valid  <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            if (mem_rd_en) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            inflight_p1 <= mem_rd_en;
            buf_cnt     <= cnt_nxt;
            dout        <= head_nxt;
            tail        <= tail_nxt;
            dout_valid  <= (cnt_nxt != 2'd0);
            if (overrun) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: RAM and writer model, scoreboard of written words
// checked in order by a monitor, plus cycle-accurate directed checks.
module tb_fifo_rd_ctrl;
    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW:0]   wr_ptr;
    logic [DW-1:0] mem_rdata;
    logic          dout_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_raddr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic [AW:0]   level;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          ovf_err;

    fifo_rd_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .wr_ptr(wr_ptr), .mem_rdata(mem_rdata),
        .dout_ready(dout_ready), .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
        .rd_ptr(rd_ptr), .empty(empty), .level(level), .dout(dout),
        .dout_valid(dout_valid), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_raddr];
    end

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_issue  = 0;
    bit            sb_en    = 1'b1;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] sb_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        ram[wr_ptr[AW-1:0]] = d;
        wr_ptr = wr_ptr + 1'b1;
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        wr_ptr = '0;
        exp_q.delete();
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_rd_ptr", rd_ptr, 0);
        chk("rst_ovf_err", ovf_err, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: no read while empty, and delivered words in write order
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_rd_en) begin
                n_issue++;
                chk("issue_while_empty", empty, 0);
            end
            if (sb_en && dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", dout_valid, 0);
                end else begin
                    sb_exp = exp_q.pop_front();
                    chk("data_order", dout, sb_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int base;
        int sent;
        logic [AW:0] lv;
        rstn       = 1'b0;
        wr_ptr     = '0;
        dout_ready = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;

        // reset and idle
        repeat (2) @(negedge clk);
        chk("reset_rd_ptr", rd_ptr, 0);
        chk("reset_dout_valid", dout_valid, 0);
        chk("reset_ovf", ovf_err, 0);
        chk("reset_rd_en", mem_rd_en, 0);
        chk("reset_empty", empty, 1);
        tick();
        rstn = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("idle_rd_en", mem_rd_en, 0);
        chk("idle_empty", empty, 1);
        chk("idle_level", level, 0);
        chk("idle_issues", n_issue, 0);

        // single word latency
        tick();
        dout_ready = 1'b1;
        write_word(8'hA5);
        @(negedge clk);
        chk("single_rd_en", mem_rd_en, 1);
        chk("single_raddr", mem_raddr, 0);
        tick();
        @(negedge clk);
        chk("single_valid_n1", dout_valid, 0);
        tick();
        @(negedge clk);
        chk("single_valid_n2", dout_valid, 1);
        chk("single_dout", dout, 8'hA5);
        tick();
        @(negedge clk);
        chk("single_valid_n3", dout_valid, 0);
        chk("single_rd_ptr", rd_ptr, 1);
        chk("single_empty", empty, 1);

        // backpressure: only two prefetches, then in-order streaming
        tick();
        dout_ready = 1'b0;
        base = n_issue;
        for (int k = 1; k <= 5; k++) write_word(k[DW-1:0]);
        repeat (6) tick();
        @(negedge clk);
        chk("bp_issues", n_issue - base, 2);
        chk("bp_rd_ptr", rd_ptr, 3);
        chk("bp_level", level, 3);
        chk("bp_valid", dout_valid, 1);
        chk("bp_dout_held", dout, 8'h01);
        chk("bp_rd_en", mem_rd_en, 0);
        tick();
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stream_valid", dout_valid, 1);
            chk("bp_stream_dout", dout, i + 1);
            tick();
        end
        @(negedge clk);
        chk("bp_stream_end", dout_valid, 0);

        // wrap: 100 random words with random backpressure
        tick();
        do_reset();
        sent = 0;
        for (int c = 0; c < 3000 && sent < 100; c++) begin
            dout_ready = ($urandom_range(0, 3) != 0);
            lv = wr_ptr - rd_ptr;
            if (lv < 6'd32 && $urandom_range(0, 1) == 1) begin
                write_word($urandom_range(0, 255));
                sent++;
            end
            tick();
        end
        chk("wrap_sent", sent, 100);
        dout_ready = 1'b1;
        drain(200);
        @(negedge clk);
        chk("wrap_rd_ptr", rd_ptr, 36);
        chk("wrap_ovf", ovf_err, 0);
        chk("wrap_empty", empty, 1);

        // full depth and overrun
        tick();
        do_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 32; i++) write_word(i + 8'h40);
        repeat (4) tick();
        @(negedge clk);
        chk("full_level", level, 30);
        chk("full_rd_ptr", rd_ptr, 2);
        chk("full_ovf", ovf_err, 0);
        chk("full_dout", dout, 8'h40);
        tick();
        sb_en  = 1'b0;
        wr_ptr = rd_ptr + 6'd33;
        @(negedge clk);
        chk("ovf_before_edge", ovf_err, 0);
        tick();
        @(negedge clk);
        chk("ovf_set", ovf_err, 1);
        tick();
        wr_ptr = rd_ptr;
        repeat (3) tick();
        @(negedge clk);
        chk("ovf_sticky", ovf_err, 1);

        // reset while a word is buffered and another in flight
        tick();
        do_reset();
        sb_en      = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) write_word(i + 8'h90);
        tick();
        tick();
        chk("midrst_pre_valid", dout_valid, 1);
        rstn   = 1'b0;
        wr_ptr = '0;
        exp_q.delete();
        #1;
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_rd_ptr", rd_ptr, 0);
        chk("midrst_ovf", ovf_err, 0);
        tick();
        rstn = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("midrst_no_stale", dout_valid, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
